// File: rtl/mioc_dram_seq.sv
// mioc_dram_seq: DRAM timing sequencer for the MIOC memory path.
//
// Turns the buffered Z80 strobes into RAS_N, MUX and per-bank CAS_N for the DRAM
// array. It inserts programmable wait states and runs RAS-only refresh cycles.
//
// Optional feature: define MIOC_AUTO_REFRESH_EN to enable autonomous refresh while
// the bus is granted to DMA. Without the macro, REF_ACTIVE and RFSH_ROW are tied to 0.
//
// Ports:
//   B_PHI       in   system clock, rising-edge active
//   RST_N       in   asynchronous active-low reset
//   BMREQ_N     in   buffered memory request
//   BRFSH_N     in   buffered refresh strobe
//   BRD_N       in   buffered read strobe
//   N_BWR       in   buffered write strobe
//   BUSAK_N     in   bus acknowledge (low = DMA owns the bus)
//   DRAM_HIT    in   address decode hit on DRAM
//   BANK_SEL    in   bank index from decode
//   RAS_N       out  row address strobe
//   MUX         out  address mux select (1 = column)
//   CAS_N       out  one-hot active-low column strobes
//   WAIT_N      out  wait request to the CPU
//   BUSY        out  sequencer not idle
//   REF_ACTIVE  out  auto-refresh in progress (row address comes from RFSH_ROW)
//   RFSH_ROW    out  auto-refresh row address
module mioc_dram_seq #(
    parameter int unsigned NBANKS          = 2,
    parameter int unsigned BANK_AW         = 1,
    parameter int unsigned RAS_TO_MUX      = 1,
    parameter int unsigned MUX_TO_CAS      = 1,
    parameter int unsigned WAIT_CYCLES     = 1,
    parameter int unsigned PRECHARGE       = 1,
    parameter int unsigned REFRESH_TIMEOUT = 16,
    parameter int unsigned ROW_W           = 7
) (
    input  logic               B_PHI,
    input  logic               RST_N,
    input  logic               BMREQ_N,
    input  logic               BRFSH_N,
    input  logic               BRD_N,
    input  logic               N_BWR,
    input  logic               BUSAK_N,
    input  logic               DRAM_HIT,
    input  logic [BANK_AW-1:0] BANK_SEL,
    output logic               RAS_N,
    output logic               MUX,
    output logic [NBANKS-1:0]  CAS_N,
    output logic               WAIT_N,
    output logic               BUSY,
    output logic               REF_ACTIVE,
    output logic [ROW_W-1:0]   RFSH_ROW
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRas   = 3'd1;
    localparam logic [2:0] StMuxs  = 3'd2;
    localparam logic [2:0] StCas   = 3'd3;
    localparam logic [2:0] StHold  = 3'd4;
    localparam logic [2:0] StPrech = 3'd5;
    localparam logic [2:0] StRfsh  = 3'd6;
    localparam logic [2:0] StArfsh = 3'd7;

    // Terminal counts: each timed state leaves when the dwell counter hits its last cycle.
    // CAS always lasts at least one cycle, even with no wait states.
    localparam logic [15:0] RasLast   = 16'(RAS_TO_MUX - 1);
    localparam logic [15:0] MuxLast   = 16'(MUX_TO_CAS - 1);
    localparam logic [15:0] CasLast   = (WAIT_CYCLES == 0) ? 16'd0 : 16'(WAIT_CYCLES - 1);
    localparam logic [15:0] PrechLast = 16'(PRECHARGE - 1);
    localparam logic [15:0] ArfLast   = 16'(RAS_TO_MUX + MUX_TO_CAS);
    localparam bit          HasWait   = (WAIT_CYCLES != 0);

    localparam logic [BANK_AW:0] NbanksW = (BANK_AW + 1)'(NBANKS);

    logic [2:0]         state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [BANK_AW-1:0] bank_q, bank_d;
    logic [NBANKS-1:0]  cas_n_d;
    logic               cpu_req;
    logic               bank_ok;
    logic               arf_due;

    assign cpu_req = !BMREQ_N && DRAM_HIT && (!BRD_N || !N_BWR);
    assign bank_ok = ({1'b0, BANK_SEL} < NbanksW);

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        case (state_q)
            StIdle: begin
                if (!BMREQ_N && !BRFSH_N) begin
                    state_d = StRfsh;
                end else if (cpu_req && bank_ok) begin
                    state_d = StRas;
                    bank_d  = BANK_SEL;
                end else if (arf_due) begin
                    state_d = StArfsh;
                end
            end
            // Releasing the request before CAS aborts the cycle without a column strobe.
            StRas: begin
                if (BMREQ_N)                state_d = StPrech;
                else if (cnt_q == RasLast)  state_d = StMuxs;
            end
            StMuxs: begin
                if (BMREQ_N)                state_d = StPrech;
                else if (cnt_q == MuxLast)  state_d = StCas;
            end
            StCas: begin
                if (cnt_q == CasLast)       state_d = StHold;
            end
            StHold: begin
                if (BMREQ_N)                state_d = StPrech;
            end
            StRfsh: begin
                if (BMREQ_N)                state_d = StPrech;
            end
            StPrech: begin
                if (cnt_q == PrechLast)     state_d = StIdle;
            end
            StArfsh: begin
                if (cnt_q == ArfLast)       state_d = StPrech;
            end
            default: state_d = StIdle;
        endcase
    end

    // Dwell counter restarts on every state change.
    assign cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;

    always_comb begin
        cas_n_d = '1;
        if (state_d == StCas || state_d == StHold) begin
            for (int unsigned i = 0; i < NBANKS; i++) begin
                if (bank_d == BANK_AW'(i)) cas_n_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
        end
    end

    // Outputs are registered decodes of the next state, so they change together
    // with the state register.
    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            RAS_N  <= 1'b1;
            MUX    <= 1'b0;
            CAS_N  <= '1;
            WAIT_N <= 1'b1;
            BUSY   <= 1'b0;
        end else begin
            RAS_N  <= !(state_d inside {StRas, StMuxs, StCas, StHold, StRfsh, StArfsh});
            MUX    <= (state_d inside {StMuxs, StCas, StHold});
            CAS_N  <= cas_n_d;
            WAIT_N <= !(HasWait && state_d == StCas);
            BUSY   <= (state_d != StIdle);
        end
    end

`ifdef MIOC_AUTO_REFRESH_EN
    localparam int unsigned     TmrW   = $clog2(REFRESH_TIMEOUT + 1);
    localparam logic [TmrW-1:0] TmrMax = TmrW'(REFRESH_TIMEOUT);

    logic [TmrW-1:0] timer_q, timer_d;
    logic            arf_exit;

    assign arf_exit = (state_q == StArfsh) && (state_d != StArfsh);
    assign arf_due  = (timer_q >= TmrMax);

    // Timer only runs while DMA holds the bus; it saturates once a refresh is due.
    always_comb begin
        timer_d = timer_q;
        if (BUSAK_N || state_d == StRfsh || arf_exit) begin
            timer_d = '0;
        end else if (state_q != StRfsh && timer_q < TmrMax) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            timer_q    <= '0;
            RFSH_ROW   <= '0;
            REF_ACTIVE <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            REF_ACTIVE <= (state_d == StArfsh);
            if (arf_exit) RFSH_ROW <= RFSH_ROW + 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign arf_due    = 1'b0;
    assign REF_ACTIVE = 1'b0;
    assign RFSH_ROW   = '0;
    assign unused_cfg = BUSAK_N ^ (REFRESH_TIMEOUT == 0);
`endif

endmodule
